// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweep checker.
package tt_pkg;

    localparam int unsigned MAX_N_VARS = 5;
    localparam int unsigned DEF_N_VARS = 4;
    localparam int unsigned NUM_VEC    = 1 << DEF_N_VARS;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        FINISH
    } tt_state_e;

    // Sweep length for a given number of function inputs.
    function automatic int unsigned num_vec(input int unsigned n_vars);
        return 32'(1) << n_vars;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter; o_expire_c pulses in the last enabled cycle of the count.
module tt_settle_timer #(
    parameter int unsigned CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire_c
);

    localparam int unsigned CNT_W = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(CYCLES);
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_expire_c = i_en && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every input combination of an external combinational function, captures the
// resulting minterm vector and compares it against a latched expected mask.
module truth_table_checker
    import tt_pkg::*;
#(
    parameter int unsigned N_VARS = DEF_N_VARS,
    parameter int unsigned SETTLE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [(1<<N_VARS)-1:0]   expected,
    output logic [N_VARS-1:0]        vec_out,
    input  logic                     f_in,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [(1<<N_VARS)-1:0]   captured,
    output logic [N_VARS:0]          mismatch_cnt,
    output logic [N_VARS-1:0]        first_err,
    output logic                     err_valid
);

    localparam int unsigned VEC_CNT  = num_vec(N_VARS);
    localparam int unsigned CNT_W    = N_VARS + 1;
    localparam int unsigned LAST_IDX = VEC_CNT - 1;

    tt_state_e           r_state;
    logic [N_VARS-1:0]   r_idx;
    logic [VEC_CNT-1:0]  r_exp;
    logic [VEC_CNT-1:0]  r_captured;
    logic [CNT_W-1:0]    r_mismatch_cnt;
    logic [N_VARS-1:0]   r_first_err;
    logic                r_err_valid;
    logic                r_pass;
    logic                r_busy;
    logic                r_done;

    logic w_last;
    logic w_miss;
    logic w_load;
    logic w_expire;

    assign w_last = (r_idx == N_VARS'(LAST_IDX));
    assign w_miss = f_in ^ r_exp[r_idx];
    // Timer restarts on accept and whenever a new vector is driven.
    assign w_load = ((r_state == IDLE) && start) || ((r_state == SAMPLE) && !w_last);

    tt_settle_timer #(
        .CYCLES (SETTLE)
    ) u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_en       (r_state == WAIT),
        .o_expire_c (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_idx          <= '0;
            r_exp          <= '0;
            r_captured     <= '0;
            r_mismatch_cnt <= '0;
            r_first_err    <= '0;
            r_err_valid    <= 1'b0;
            r_pass         <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_exp          <= expected;
                        r_captured     <= '0;
                        r_mismatch_cnt <= '0;
                        r_first_err    <= '0;
                        r_err_valid    <= 1'b0;
                        r_pass         <= 1'b0;
                        r_idx          <= '0;
                        r_busy         <= 1'b1;
                        r_state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_expire) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    r_captured[r_idx] <= f_in;
                    if (w_miss) begin
                        r_mismatch_cnt <= r_mismatch_cnt + CNT_W'(1);
                        if (!r_err_valid) begin
                            r_first_err <= r_idx;
                            r_err_valid <= 1'b1;
                        end
                    end
                    if (w_last) begin
                        r_state <= FINISH;
                    end else begin
                        r_idx   <= r_idx + N_VARS'(1);
                        r_state <= WAIT;
                    end
                end
                FINISH: begin
                    r_done  <= 1'b1;
                    r_pass  <= (r_mismatch_cnt == '0);
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign vec_out      = r_idx;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign captured     = r_captured;
    assign mismatch_cnt = r_mismatch_cnt;
    assign first_err    = r_first_err;
    assign err_valid    = r_err_valid;

endmodule

// File: tb/tb_truth_table_checker.sv
// Randomized scoreboard bench for truth_table_checker (N_VARS=4, SETTLE=2).
module tb_truth_table_checker;

    localparam int N   = 4;
    localparam int S   = 2;
    localparam int NV  = 1 << N;
    localparam int LAT = 1 + NV * (S + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NV-1:0] expected;
    logic [N-1:0]  vec_out;
    logic          f_in;
    logic          busy;
    logic          done;
    logic          pass;
    logic [NV-1:0] captured;
    logic [N:0]    mismatch_cnt;
    logic [N-1:0]  first_err;
    logic          err_valid;

    truth_table_checker #(
        .N_VARS (N),
        .SETTLE (S)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .expected     (expected),
        .vec_out      (vec_out),
        .f_in         (f_in),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .captured     (captured),
        .mismatch_cnt (mismatch_cnt),
        .first_err    (first_err),
        .err_valid    (err_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Function under sweep: its output follows vec_out only after S edges, so early sampling shows.
    logic [NV-1:0] fn;
    logic [N-1:0]  d0, d1;
    always @(posedge clk) begin
        d0 <= vec_out;
        d1 <= d0;
    end
    assign f_in = fn[d1];

    typedef struct {
        int            done_cyc;
        logic [NV-1:0] cap;
        int            cnt;
        int            ferr;
        bit            ev;
        bit            ps;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic exp_t model(input logic [NV-1:0] f, input logic [NV-1:0] ex, input int acc);
        exp_t          r;
        logic [NV-1:0] diff;
        diff       = f ^ ex;
        r.cap      = f;
        r.cnt      = 0;
        r.ferr     = -1;
        for (int i = 0; i < NV; i++) begin
            if (diff[i]) begin
                r.cnt++;
                if (r.ferr < 0) r.ferr = i;
            end
        end
        r.ev       = (r.cnt != 0);
        r.ps       = (r.cnt == 0);
        r.done_cyc = acc + LAT;
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding sweep.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("spurious_done", 32'(1), 32'(0));
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
                chk("captured", 32'(captured), 32'(e.cap));
                chk("mismatch_cnt", 32'(mismatch_cnt), 32'(e.cnt));
                chk("err_valid", 32'(err_valid), 32'(e.ev));
                chk("pass", 32'(pass), 32'(e.ps));
                if (e.ev) chk("first_err", 32'(first_err), 32'(e.ferr));
                chk("vec_out_at_done", 32'(vec_out), 32'(NV - 1));
                chk("busy_at_done", 32'(busy), 32'(0));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_sweep(input logic [NV-1:0] f, input logic [NV-1:0] ex, output int acc);
        @(negedge clk);
        fn       = f;
        expected = ex;
        start    = 1'b1;
        @(negedge clk);
        acc      = cyc;
        start    = 1'b0;
        expected = NV'($urandom);
        sbq.push_back(model(f, ex, acc));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_pass"}, 32'(pass), 32'(0));
        chk({tag, "_captured"}, 32'(captured), 32'(0));
        chk({tag, "_mismatch"}, 32'(mismatch_cnt), 32'(0));
        chk({tag, "_first_err"}, 32'(first_err), 32'(0));
        chk({tag, "_err_valid"}, 32'(err_valid), 32'(0));
        chk({tag, "_vec_out"}, 32'(vec_out), 32'(0));
    endtask

    initial begin
        int            acc;
        logic [NV-1:0] f;
        logic [NV-1:0] ex;

        rst      = 1'b1;
        start    = 1'b0;
        expected = '0;
        fn       = '0;
        idle(3);
        check_all_zero("reset");
        rst = 1'b0;

        // Constant-zero function against a mask with four ones starting at minterm 4.
        start_sweep(NV'(0), NV'(16'h00F0), acc);
        idle(LAT + 3);
        chk("hold_captured", 32'(captured), 32'(0));
        chk("hold_mismatch", 32'(mismatch_cnt), 32'(4));
        chk("hold_first_err", 32'(first_err), 32'(4));
        chk("hold_vec_out", 32'(vec_out), 32'(NV - 1));
        chk("hold_done_low", 32'(done), 32'(0));

        // Random functions: exact match, single-bit error, or unrelated mask.
        for (int i = 0; i < 9; i++) begin
            f = NV'($urandom);
            case (i % 3)
                0:       ex = f;
                1:       ex = f ^ (NV'(1) << $urandom_range(NV - 1, 0));
                default: ex = NV'($urandom);
            endcase
            start_sweep(f, ex, acc);
            idle(LAT + 1);
        end

        // Start pulsed mid-sweep is ignored.
        f = NV'($urandom);
        start_sweep(f, f ^ NV'(16'h0120), acc);
        idle(15);
        chk("vec_at_extra_start", 32'(vec_out), 32'(5));
        chk("busy_mid_sweep", 32'(busy), 32'(1));
        start    = 1'b1;
        expected = ~f;
        @(negedge clk);
        start = 1'b0;
        idle(LAT - 16 + 3);

        // Reset mid-sweep abandons the sweep without a done pulse.
        start_sweep(NV'($urandom), NV'($urandom), acc);
        idle(15);
        chk("vec_before_reset", 32'(vec_out), 32'(5));
        rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midreset");
        idle(LAT + 2);
        f = NV'($urandom);
        start_sweep(f, f, acc);
        idle(LAT + 2);

        // Back-to-back: start held through done, second mask wrong.
        f = NV'($urandom);
        @(negedge clk);
        fn       = f;
        expected = f;
        start    = 1'b1;
        @(negedge clk);
        acc = cyc;
        sbq.push_back(model(f, f, acc));
        expected = ~f;
        sbq.push_back(model(f, ~f, acc + LAT + 1));
        idle(LAT);
        @(negedge clk);
        start    = 1'b0;
        expected = NV'($urandom);
        idle(LAT + 3);

        chk("scoreboard_empty", 32'(sbq.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
